// File: rtl/nes_pkg.sv
// Shared definitions for the NES controller interface.
//   - Button bit positions within the parallel button byte
//     {a,b,select,start,up,down,left,right}.
//   - Number of serial bits per poll.
//   - State encoding of the console-side poll engine.
package nes_pkg;

    localparam int NES_NUM_BITS   = 8;

    localparam int NES_BTN_A      = 7;
    localparam int NES_BTN_B      = 6;
    localparam int NES_BTN_SELECT = 5;
    localparam int NES_BTN_START  = 4;
    localparam int NES_BTN_UP     = 3;
    localparam int NES_BTN_DOWN   = 2;
    localparam int NES_BTN_LEFT   = 1;
    localparam int NES_BTN_RIGHT  = 0;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LATCH_LO = 3'd1,
        LATCH_HI = 3'd2,
        SETTLE   = 3'd3,
        SHIFT_HI = 3'd4,
        SHIFT_LO = 3'd5,
        DONE     = 3'd6
    } nes_state_e;

endpackage

// File: rtl/nes_controller_reader_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous pad input.
// Ports:
//   clk_i  - destination clock
//   rst_i  - asynchronous, active-high reset; both flops load RESET_VAL
//   d_i    - asynchronous input
//   q_o    - synchronised output (two clk_i edges of latency)
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/nes_controller_reader.sv
// Console-side NES controller poll engine.
// Drives the controller latch and clock lines, deserialises the active-low
// serial data and presents an active-high button byte with a one-cycle
// valid strobe.
// Ports:
//   clk_i      - system clock
//   rst_i      - asynchronous, active-high reset
//   start_i    - poll request, only looked at while idle
//   serial_ni  - controller serial data (active-low, asynchronous)
//   latch_o    - controller latch (active-high)
//   nes_clk_o  - controller clock, idle low, data shifts on rising edge
//   buttons_o  - {a,b,select,start,up,down,left,right}, active-high
//   valid_o    - one-cycle strobe, buttons_o updated in the same cycle
//   busy_o     - high from the accepting edge through the valid_o cycle
// Handshake: start_i is a level request; it is accepted on any edge where the
// engine is idle and ignored otherwise (no queuing). valid_o is a pure strobe
// with no back-pressure.
module nes_controller_reader
    import nes_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       serial_ni,
    output logic       latch_o,
    output logic       nes_clk_o,
    output logic [7:0] buttons_o,
    output logic       valid_o,
    output logic       busy_o
);

    localparam int PW = $clog2(CLK_DIV);

    nes_state_e              state_q;
    logic [PW-1:0]           phase_q;
    logic [2:0]              bit_q;
    logic [NES_NUM_BITS-1:0] shift_q;
    logic                    latch_q;
    logic                    nes_clk_q;
    logic [7:0]              buttons_q;
    logic                    valid_q;
    logic                    busy_q;

    logic serial_s;
    logic phase_last;

    // Line idles high (no controller / no buttons), so the flops reset to 1.
    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (serial_ni),
        .q_o   (serial_s)
    );

    assign phase_last = (phase_q == PW'(CLK_DIV - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            latch_q   <= 1'b0;
            nes_clk_q <= 1'b0;
            buttons_q <= 8'h00;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;

            // Phase counter runs in every timed state and wraps at each
            // phase boundary, so every timed state lasts exactly CLK_DIV.
            if (state_q != IDLE && state_q != DONE) begin
                phase_q <= phase_last ? '0 : phase_q + 1'b1;
            end else begin
                phase_q <= '0;
            end

            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= LATCH_LO;
                        latch_q <= 1'b1;
                        busy_q  <= 1'b1;
                        bit_q   <= '0;
                    end
                end
                LATCH_LO: begin
                    if (phase_last) begin
                        state_q   <= LATCH_HI;
                        nes_clk_q <= 1'b1;
                    end
                end
                LATCH_HI: begin
                    if (phase_last) begin
                        state_q   <= SETTLE;
                        latch_q   <= 1'b0;
                        nes_clk_q <= 1'b0;
                    end
                end
                SETTLE: begin
                    // First sample (A) ends up in shift_q[7] after 8 shifts.
                    if (phase_last) begin
                        shift_q   <= {shift_q[NES_NUM_BITS-2:0], serial_s};
                        state_q   <= SHIFT_HI;
                        nes_clk_q <= 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (phase_last) begin
                        shift_q   <= {shift_q[NES_NUM_BITS-2:0], serial_s};
                        state_q   <= SHIFT_LO;
                        nes_clk_q <= 1'b0;
                    end
                end
                SHIFT_LO: begin
                    if (phase_last) begin
                        if (bit_q == 3'd6) begin
                            state_q   <= DONE;
                            buttons_q <= ~shift_q;
                            valid_q   <= 1'b1;
                        end else begin
                            bit_q     <= bit_q + 3'd1;
                            state_q   <= SHIFT_HI;
                            nes_clk_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    latch_q   <= 1'b0;
                    nes_clk_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign latch_o   = latch_q;
    assign nes_clk_o = nes_clk_q;
    assign buttons_o = buttons_q;
    assign valid_o   = valid_q;
    assign busy_o    = busy_q;

endmodule

// File: doc/nes_controller_reader.md
Name: nes_controller_reader

Overview:
Console-side poll engine that drives the latch and clock lines of an NES controller and deserialises its active-low serial data. It sits directly upstream/downstream of the controller shift-register model: it generates that model's latch and clock inputs and consumes its serial output. The block presents a parallel, active-high button byte with a one-cycle valid strobe to the rest of the design.

Parameters:
CLK_DIV, 4, system clock cycles per controller-clock half-period (T); legal range >= 4 so the input synchroniser settles before sampling.

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous, active-high reset
start_i  input  1  poll request; sampled only in IDLE
serial_ni  input  1  controller serial data, active-low, asynchronous to clk_i
latch_o  output  1  controller latch, active-high
nes_clk_o  output  1  controller clock; idle low; data shifts on its rising edge
buttons_o  output  8  {a,b,select,start,up,down,left,right}, active-high (inverted samples)
valid_o  output  1  one-cycle strobe; buttons_o updated in the same cycle
busy_o  output  1  high from the accepting edge until the valid_o cycle, inclusive

Behaviour:
- Interface: one clock (clk_i); reset is asynchronous and active-high (rst_i).
- Reset values: latch_o=0, nes_clk_o=0, buttons_o=8'h00, valid_o=0, busy_o=0, state=IDLE, synchroniser flops=1 (line idle, no buttons).
- serial_ni passes through a 2-flop synchroniser. All sampling uses the synchronised value.
- Phase counter counts 0..CLK_DIV-1. Each phase lasts exactly T = CLK_DIV cycles.
- All outputs are registered.
- IDLE: latch_o=0, nes_clk_o=0. If start_i=1 on an edge, go to LATCH_LO, busy_o=1 and latch_o=1 from that edge.
- LATCH_LO (T): latch_o=1, nes_clk_o=0.
- LATCH_HI (T): latch_o=1, nes_clk_o=1. This rising edge loads a synchronous-latch controller.
- SETTLE (T): latch_o=0, nes_clk_o=0. On its last cycle, sample the bit into shift[7] (A).
- SHIFT_HI (T): nes_clk_o=1. On its last cycle, sample the next bit into the next lower index.
- SHIFT_LO (T): nes_clk_o=0. After the 7th SHIFT_LO go to DONE; otherwise go to SHIFT_HI.
- Bit counter: counts 7 SHIFT_HI/LO pairs, so exactly 8 nes_clk_o rising edges occur per poll (1 during latch, 7 shifting).
- DONE (1 cycle): buttons_o <= ~shift, valid_o=1, busy_o=1. Next state is IDLE.
- Latency: valid_o is asserted exactly 17*CLK_DIV edges after the edge that accepted start_i (68 for CLK_DIV=4).
- buttons_o holds its last value between polls. It changes only in the valid_o cycle.
- start_i while busy is ignored, not queued.
- start_i held high continuously: a new poll is accepted on the first IDLE cycle after DONE (back-to-back polls, 1 idle cycle gap).
- Unplugged controller (serial_ni pulled high): all samples are 1, so buttons_o=8'h00 with valid_o still pulsed.
- Reset mid-poll: all outputs and state return to reset values immediately. No valid_o pulse is produced, and the partial shift contents are discarded.
- Timing correctness does not depend on whether the controller loads synchronously or asynchronously: latch_o spans a full clock pulse, and data is sampled ≥ T-2 cycles after each edge.

Decomposition:
- Shared package nes_pkg holds:
  - button bit indices NES_BTN_A=7 … NES_BTN_RIGHT=0
  - NES_NUM_BITS=8
  - the reader state enum {IDLE, LATCH_LO, LATCH_HI, SETTLE, SHIFT_HI, SHIFT_LO, DONE}
- One sub-module, sync_2ff: a 2-flop synchroniser with an async-reset value parameter. It is reusable for other pad inputs.
- FSM, phase counter, bit counter and shift register stay in the top module.

Test Plan:
- Loopback to controller model (sync latch), CLK_DIV=4, buttons_ni=8'b0111_1110, pulse start_i -> valid_o at edge 68, buttons_o=8'h81, exactly 8 nes_clk_o rising edges, latch_o high for 8 cycles.
- Same stimulus with async-latch controller variant, buttons_ni=8'b1010_1010 -> buttons_o=8'h55; same timing.
- serial_ni tied 1 (unplugged), start_i pulsed -> valid_o at edge 68, buttons_o=8'h00.
- start_i re-pulsed at edge 20 of an active poll -> ignored; exactly one valid_o. Then start_i held high -> second poll latch_o rises 1 cycle after DONE.
- rst_i asserted at edge 40 of a poll, released at 45 -> outputs zero asynchronously, no valid_o, buttons_o=8'h00. A subsequent poll with buttons_ni=8'hFE -> buttons_o=8'h01.
- CLK_DIV=7 with buttons_ni=8'b1101_1111 -> valid_o at edge 119, buttons_o=8'h20.
